// File: rtl/event_or_capture.sv
// Synchronizes four async event sources, detects the mode-selected event expression and
// captures din into a one-entry valid/ready holding register with counter and overrun flag.
module event_or_capture #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             src_a,
  input  logic             src_b,
  input  logic             trig,
  input  logic             enable,
  input  logic             mode,
  input  logic [WIDTH-1:0] din,
  input  logic             clr,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [3:0]       evt_src,
  output logic [CNT_W-1:0] evt_count,
  output logic             overrun
);

  typedef enum logic [1:0] {StWarmup, StEmpty, StFull} state_e;

  localparam logic [2:0] WarmLast = 3'(SYNC_STAGES);

  state_e           state_q, state_d;
  logic [2:0]       warm_q, warm_d;
  logic [3:0]       sync_q [SYNC_STAGES];
  logic [3:0]       hist_q;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [3:0]       src_q, src_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovr_q, ovr_d;

  logic [3:0] last, rise, edg, fired;
  logic       ev;

  // Bit order everywhere is {enable, trig, src_b, src_a}.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= '0;
      hist_q <= '0;
    end else begin
      sync_q[0] <= {enable, trig, src_b, src_a};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  always_comb begin
    last  = sync_q[SYNC_STAGES-1];
    rise  = last & ~hist_q;
    edg   = last ^ hist_q;
    fired = mode ? {1'b0, edg[2], rise[1], rise[0]} : {edg[3], edg[2], 2'b00};
    ev    = (|fired) && (state_q != StWarmup);
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    dout_d  = dout_q;
    src_d   = src_q;
    cnt_d   = cnt_q;
    ovr_d   = ovr_q;

    unique case (state_q)
      StWarmup: begin
        warm_d = warm_q + 3'd1;
        if (warm_q == WarmLast) state_d = StEmpty;
      end
      StEmpty: begin
        if (ev) begin
          dout_d  = din;
          src_d   = fired;
          state_d = StFull;
        end
      end
      StFull: begin
        if (dout_ready) begin
          if (ev) begin
            dout_d = din;
            src_d  = fired;
          end else begin
            state_d = StEmpty;
          end
        end else if (ev) begin
          ovr_d = 1'b1;
        end
      end
      default: state_d = StWarmup;
    endcase

    if (ev && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    // Clear wins over both counting and a same-cycle overrun.
    if (clr) begin
      cnt_d = '0;
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StWarmup;
      warm_q  <= '0;
      dout_q  <= '0;
      src_q   <= '0;
      cnt_q   <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
      dout_q  <= dout_d;
      src_q   <= src_d;
      cnt_q   <= cnt_d;
      ovr_q   <= ovr_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = (state_q == StFull);
  assign evt_src    = src_q;
  assign evt_count  = cnt_q;
  assign overrun    = ovr_q;

endmodule
